cfg_loader: RTL
===============

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bitstream word width.
REQ-002 SHALL have parameter CHAIN_LEN, default 256: total configuration chain length in bits (one SB of WIDTH 32 = 256).
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-004 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle load request.
REQ-006 SHALL have port word_in, input, WORD_W: bitstream word, sent MSB first.
REQ-007 SHALL have port word_valid, input, 1: word_in valid.
REQ-008 SHALL have port word_ready, output, 1: loader accepts word_in this cycle.
REQ-009 SHALL have port config_data_out, output, 1: serial bit to the chain head's config_data_in.
REQ-010 SHALL have port config_en, output, 1: chain shift enable.
REQ-011 SHALL have port config_data_in, input, 1: chain tail's config_data_out.
REQ-012 SHALL have ports busy, done and crc_err, each output, 1: status.

Function
REQ-013 SHALL implement FSM IDLE, LOAD, VERIFY, DONE.
REQ-014 IDLE/DONE + start SHALL go to LOAD, clear bit/word counters and crc_err, and set both CRCs to 0xFFFF.
REQ-015 start in LOAD/VERIFY SHALL be ignored.
REQ-016 A word SHALL transfer on word_valid && word_ready only.
REQ-017 word_ready SHALL be 1 only in LOAD, with the word buffer holding <=1 unshifted bit, while fewer than ceil(CHAIN_LEN/WORD_W) words have been accepted.
REQ-018 Gapless streaming SHALL hold: a word accepted at cycle t shifts its first bit at t+1.
REQ-019 In LOAD, a buffer bit available SHALL give config_en=1 and config_data_out=current MSB, shifting the buffer left 1.
REQ-020 With no buffer bit, config_en SHALL be 0 (stall) and config_data_out SHALL hold 0.
REQ-021 Each shifted LOAD bit SHALL update load CRC-16-CCITT (poly 0x1021, serial, MSB-first).
REQ-022 After exactly CHAIN_LEN LOAD shifts, the FSM SHALL go to VERIFY.
REQ-023 Unshifted bits of the final partial word SHALL be discarded.
REQ-024 VERIFY SHALL assert config_en for exactly CHAIN_LEN consecutive cycles with config_data_out=config_data_in (recirculation restores chain contents) and update the verify CRC with config_data_in.
REQ-025 On the last VERIFY cycle's following edge, the FSM SHALL go to DONE and set crc_err=(load CRC != verify CRC).
REQ-026 busy SHALL be 1 in LOAD/VERIFY.
REQ-027 done SHALL be 1 in DONE only.
REQ-028 crc_err SHALL be sticky until the next accepted start.
REQ-029 Bit/word counters SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.

Reset
REQ-030 nrst low SHALL force, immediately: FSM IDLE, config_en 0, config_data_out 0, word_ready 0, busy 0, done 0, crc_err 0, counters 0, CRCs 0xFFFF.
REQ-031 Reset mid-LOAD/VERIFY SHALL abandon the operation; chain contents are then undefined and a new start fully reloads.

Structure
REQ-032 Package cfg_pkg SHALL hold the state enum, CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
REQ-033 Sub-module cfg_crc16 (serial one-bit CRC update, instantiated twice) SHALL be used.

Verification
REQ-034 SHALL cover: WORD_W=32, CHAIN_LEN=256, words 0xA5A50000+k (k=0..7), 256-bit SB-style shift model -> model equals the 8 words concatenated with word 0 at the MSB end; done 512 cycles after first shift; crc_err=0.
REQ-035 SHALL cover: word_valid low 5 cycles between words 2 and 3 -> config_en low exactly 5 cycles; 256 LOAD shifts total; crc_err=0.
REQ-036 SHALL cover: model tail stuck-at-0 during VERIFY, data 0xFFFFFFFF -> crc_err=1, done=1.
REQ-037 SHALL cover: CHAIN_LEN=40 -> exactly 2 words accepted; only the top 8 bits of word 2 shifted; word_ready 0 thereafter.
REQ-038 SHALL cover: nrst pulsed after 100 LOAD shifts -> all outputs 0 without a clock edge; a new start then loads 256 bits correctly.
REQ-039 SHALL cover: start pulsed during VERIFY -> ignored; sequence completes unchanged.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared FSM state type and CRC-16-CCITT constants for the config loader.
package cfg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/cfg_crc16.sv
// cfg_crc16: one-bit serial CRC-16-CCITT update, MSB first.
module cfg_crc16
    import cfg_pkg::*;
(
    input  logic [15:0] crc,
    input  logic        bit_in,
    output logic [15:0] crc_next
);
    assign crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: streams bitstream words serially into a config chain, then recirculates
// the chain once to check its contents against the CRC taken while loading.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 256
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_data_out,
    output logic              config_en,
    input  logic              config_data_in,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);
    localparam int CW     = $clog2(CHAIN_LEN + 1);
    localparam int BW     = $clog2(WORD_W + 1);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] NW   = CW'(NWORDS);

    state_t            state, state_next;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     buf_cnt;
    logic [CW-1:0]     bit_cnt, word_cnt;
    logic [15:0]       load_crc, verify_crc, load_crc_next, verify_crc_next;
    logic              go, accept, load_shift, last_bit;

    cfg_crc16 u_load_crc   (.crc(load_crc),   .bit_in(sreg[WORD_W-1]), .crc_next(load_crc_next));
    cfg_crc16 u_verify_crc (.crc(verify_crc), .bit_in(config_data_in), .crc_next(verify_crc_next));

    always_comb begin
        go              = start && (state == IDLE || state == DONE);
        word_ready      = state == LOAD && buf_cnt <= BW'(1) && word_cnt < NW;
        accept          = word_valid && word_ready;
        load_shift      = state == LOAD && buf_cnt != '0;
        config_en       = load_shift || state == VERIFY;
        config_data_out = state == VERIFY ? config_data_in : (load_shift ? sreg[WORD_W-1] : 1'b0);
        last_bit        = config_en && bit_cnt == LAST;
        busy            = state == LOAD || state == VERIFY;
        done            = state == DONE;
        state_next      = go ? LOAD : (last_bit ? (state == LOAD ? VERIFY : DONE) : state);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sreg       <= '0;
            buf_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            crc_err    <= 1'b0;
            load_crc   <= CRC_INIT;
            verify_crc <= CRC_INIT;
        end else if (go) begin
            buf_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            crc_err    <= 1'b0;
            load_crc   <= CRC_INIT;
            verify_crc <= CRC_INIT;
        end else begin
            if (accept) begin
                sreg     <= word_in;
                buf_cnt  <= BW'(WORD_W);
                word_cnt <= word_cnt + CW'(1);
            end else if (load_shift) begin
                sreg    <= sreg << 1;
                buf_cnt <= buf_cnt - BW'(1);
            end
            if (load_shift) load_crc <= load_crc_next;
            if (state == VERIFY) verify_crc <= verify_crc_next;
            if (config_en) bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            // leftover bits of a final partial word never reach the chain
            if (last_bit && state == LOAD) buf_cnt <= '0;
            if (last_bit && state == VERIFY) crc_err <= load_crc != verify_crc_next;
        end
    end
endmodule
